// File: rtl/ser3w_pkg.sv
// ser3w_pkg: shared widths, frame length and FSM state type
// for the three-wire serial responder.
package ser3w_pkg;

  localparam int SER3W_DATA_W    = 28;
  localparam int SER3W_ADDR_W    = 4;
  localparam int SER3W_ERR_W     = 8;
  localparam int SER3W_FRAME_LEN = SER3W_DATA_W + SER3W_ADDR_W;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser3w_state_e;

endpackage

// File: rtl/ser3w_if.sv
// ser3w_if: CS/CLK/DATA serial bus lines.
// master drives the lines, slave (responder) samples them.
interface ser3w_if;

  logic ser_cs_n;
  logic ser_sclk;
  logic ser_sdat;

  modport master (
    output ser_cs_n,
    output ser_sclk,
    output ser_sdat
  );

  modport slave (
    input ser_cs_n,
    input ser_sclk,
    input ser_sdat
  );

endinterface

// File: rtl/ser3w_sync.sv
// ser3w_sync: 2-FF synchronizer plus history stage.
// Ports: clk, rst_n, d (async) -> q (synced), rise/fall pulses.
module ser3w_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= {3{RST_VAL}};
    end else begin
      s <= {s[1:0], d};
    end
  end

  assign q    = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];

endmodule

// File: rtl/ser3w_responder.sv
// ser3w_responder: deframes 32-bit CS/CLK/DATA words into write events.
// Ports: clk, rst_n, ser (ser3w_if.slave), wr_valid/wr_addr/wr_data,
// busy, err_cnt/err_clr, rd_addr/rd_data (SER3W_READBACK_EN shadow file).
module ser3w_responder
  import ser3w_pkg::*;
#(
  parameter int DATA_W = SER3W_DATA_W,
  parameter int ADDR_W = SER3W_ADDR_W,
  parameter int ERR_W  = SER3W_ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  ser3w_if.slave            ser,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int          FLEN     = DATA_W + ADDR_W;
  localparam logic [5:0]  CNT_FULL = 6'(FLEN);
  localparam logic [5:0]  CNT_OVR  = 6'(FLEN + 1);

  logic cs_q_unused, cs_rise, cs_fall;
  logic sclk_q_unused, sclk_rise, sclk_fall_unused;
  logic sdat, sdat_rise_unused, sdat_fall_unused;

  // cs_n resets low: a frame interrupted by reset stays
  // abandoned until cs_n is seen high and falls again.
  ser3w_sync #(.RST_VAL(1'b0)) u_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser.ser_cs_n),
    .q    (cs_q_unused),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  ser3w_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser.ser_sclk),
    .q    (sclk_q_unused),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  ser3w_sync #(.RST_VAL(1'b0)) u_sdat (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser.ser_sdat),
    .q    (sdat),
    .rise (sdat_rise_unused),
    .fall (sdat_fall_unused)
  );

  ser3w_state_e    state;
  logic [5:0]      bit_cnt;
  logic [FLEN-1:0] shreg;
  logic            frame_end;
  logic            frame_ok;
  logic            frame_bad;

  assign frame_end = (state == SHIFT) && cs_rise;
  assign frame_ok  = frame_end && (bit_cnt == CNT_FULL);
  assign frame_bad = frame_end && (bit_cnt != CNT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (err_clr) begin
        err_cnt <= '0;
      end else if (frame_bad && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          // cs_n rising closes the frame; a coincident
          // sclk edge is dropped.
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (frame_ok) begin
              wr_valid <= 1'b1;
              wr_data  <= shreg[FLEN-1:ADDR_W];
              wr_addr  <= shreg[ADDR_W-1:0];
            end
          end else if (sclk_rise) begin
            shreg <= {shreg[FLEN-2:0], sdat};
            if (bit_cnt != CNT_OVR) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SER3W_READBACK_EN
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] shadow [DEPTH];

  // Read port sees the pre-write value on a same-cycle hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (frame_ok) begin
        shadow[shreg[ADDR_W-1:0]] <= shreg[FLEN-1:ADDR_W];
      end
      rd_data <= shadow[rd_addr];
    end
  end
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_ser3w_responder.sv
// tb_ser3w_responder: randomized frames against a frame-level model
// of writes, saturating error count and shadow registers.
module tb_ser3w_responder;
  import ser3w_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr;
  logic [3:0]  rd_addr;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [27:0] wr_data;
  logic        busy;
  logic [7:0]  err_cnt;
  logic [27:0] rd_data;

  always #5 clk = ~clk;

  ser3w_if bus ();

  ser3w_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ser     (bus),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .err_cnt (err_cnt),
    .err_clr (err_clr),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          pulses = 0;
  bit          busy_seen = 0;
  logic [27:0] m_data;
  logic [3:0]  m_addr;
  int          m_err;
  logic [27:0] m_shadow [16];

  always @(negedge clk) begin
    if (wr_valid === 1'b1) pulses++;
    if (busy === 1'b1) busy_seen = 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [27:0] exp_rd(logic [3:0] a);
`ifdef SER3W_READBACK_EN
    return m_shadow[a];
`else
    return 28'h0;
`endif
  endfunction

  task automatic model_reset();
    m_data = '0;
    m_addr = '0;
    m_err  = 0;
    for (int i = 0; i < 16; i++) m_shadow[i] = '0;
  endtask

  task automatic send_frame(int nbits, logic [63:0] bits, int h,
                            bit simul, bit rst_mid);
    bus.ser_cs_n = 1'b0;
    wait_clk(h);
    check("busy_open", {31'b0, busy}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (rst_mid && i == 16) begin
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(h);
      end
      bus.ser_sdat = bits[nbits-1-i];
      wait_clk(h);
      bus.ser_sclk = 1'b1;
      wait_clk(h);
      bus.ser_sclk = 1'b0;
    end
    wait_clk(h);
    if (simul) begin
      bus.ser_sdat = 1'($urandom);
      bus.ser_sclk = 1'b1;
      bus.ser_cs_n = 1'b1;
      wait_clk(h);
      bus.ser_sclk = 1'b0;
    end else begin
      bus.ser_cs_n = 1'b1;
    end
    wait_clk(h + 6);
  endtask

  task automatic check_state(int exp_p);
    logic [3:0] a;
    check("wr_pulses", pulses, exp_p);
    check("wr_data", {4'b0, wr_data}, {4'b0, m_data});
    check("wr_addr", {28'b0, wr_addr}, {28'b0, m_addr});
    check("err_cnt", {24'b0, err_cnt}, m_err);
    check("busy_idle", {31'b0, busy}, 32'd0);
    a = 4'($urandom_range(0, 15));
    rd_addr = a;
    wait_clk(2);
    check("rd_data", {4'b0, rd_data}, {4'b0, exp_rd(a)});
  endtask

  task automatic run_frame(int nbits, logic [63:0] bits, int h, bit simul);
    int exp_p;
    pulses = 0;
    send_frame(nbits, bits, h, simul, 1'b0);
    if (nbits == 32) begin
      exp_p  = 1;
      m_data = bits[31:4];
      m_addr = bits[3:0];
      m_shadow[m_addr] = m_data;
    end else begin
      exp_p = 0;
      if (m_err < 255) m_err++;
    end
    check_state(exp_p);
  endtask

  initial begin
    logic [63:0] w;
    int          nb;
    bus.ser_cs_n = 1'b1;
    bus.ser_sclk = 1'b0;
    bus.ser_sdat = 1'b0;
    err_clr = 1'b0;
    rd_addr = '0;
    model_reset();
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(6);
    check_state(0);

    run_frame(32, {32'b0, 28'hA2919A3, 4'h0}, 10, 1'b0);
`ifdef SER3W_READBACK_EN
    rd_addr = 4'h0;
    wait_clk(2);
    check("rd_first", {4'b0, rd_data}, 32'h0A2919A3);
`endif
    run_frame(31, {$urandom, $urandom}, 6, 1'b0);
    run_frame(40, {$urandom, $urandom}, 5, 1'b0);
    run_frame(32, {$urandom, $urandom}, 6, 1'b1);

    for (int k = 0; k < 40; k++) begin
      nb = ($urandom_range(0, 9) < 6) ? 32 : $urandom_range(0, 40);
      w  = {$urandom, $urandom};
      run_frame(nb, w, $urandom_range(4, 9),
                (nb == 32) && ($urandom_range(0, 3) == 0));
    end

    pulses = 0;
    send_frame(32, {$urandom, $urandom}, 5, 1'b0, 1'b1);
    model_reset();
    check_state(0);
    w = {$urandom, $urandom};
    w[3:0] = 4'hF;
    run_frame(32, w, 5, 1'b0);

    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      send_frame(0, 64'h0, 4, 1'b0, 1'b0);
      if (m_err < 255) m_err++;
    end
    check_state(0);
    check("err_sat", {24'b0, err_cnt}, 32'd255);

    bus.ser_cs_n = 1'b0;
    wait_clk(8);
    bus.ser_cs_n = 1'b1;
    wait_clk(2);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(6);
    m_err = 0;
    check("err_clr_win", {24'b0, err_cnt}, 32'd0);

    pulses = 0;
    busy_seen = 0;
    for (int k = 0; k < 50; k++) begin
      bus.ser_sclk = ~bus.ser_sclk;
      bus.ser_sdat = 1'($urandom);
      wait_clk($urandom_range(1, 6));
    end
    bus.ser_sclk = 1'b0;
    wait_clk(8);
    check("noise_busy", {31'b0, busy_seen}, 32'd0);
    check_state(0);
    run_frame(32, {$urandom, $urandom}, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
